// File: rtl/scan_pattern_driver.sv
// rtl/scan_pattern_driver.sv - two-chain scan pattern driver: loads, captures, unloads and compares
module scan_pattern_driver #(
    parameter int CHAIN_LEN   = 15,
    parameter int CAPTURE_CYC = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 REFCLK,
    input  logic                 RESET,
    input  logic                 PAT_VALID,
    output logic                 PAT_READY,
    input  logic                 PAT_LAST,
    input  logic [CHAIN_LEN-1:0] PAT_SI1,
    input  logic [CHAIN_LEN-1:0] PAT_SI2,
    input  logic [CHAIN_LEN-1:0] PAT_EXP1,
    input  logic [CHAIN_LEN-1:0] PAT_EXP2,
    output logic                 TESTMODE,
    output logic                 SE,
    output logic                 SI1,
    output logic                 SI2,
    input  logic                 SO1,
    input  logic                 SO2,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [CNT_W-1:0]     FAIL_CNT,
    output logic [CNT_W-1:0]     FIRST_FAIL_PAT
);

    localparam int BW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int CW = (CAPTURE_CYC > 1) ? $clog2(CAPTURE_CYC) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SHIFT, ST_CAPTURE, ST_WAIT_PAT, ST_UNLOAD, ST_DONE
    } state_t;

    state_t               state, state_nx;
    logic [BW-1:0]        bit_cnt;
    logic [CW-1:0]        cap_cnt;
    logic [CHAIN_LEN-1:0] si1_sr, si2_sr, cur_exp1, cur_exp2, exp1_sr, exp2_sr;
    logic                 cur_last, exp_valid;
    logic [CNT_W-1:0]     pat_idx, fail_nx;
    logic                 xfer, new_run, last_bit, last_cap, cap_exit, comparing;
    logic [1:0]           mis;
    logic [CNT_W:0]       fail_sum;

    always_ff @(posedge REFCLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        xfer      = PAT_VALID && PAT_READY;
        new_run   = xfer && (state != ST_WAIT_PAT);
        last_bit  = (bit_cnt == BIT_LAST);
        last_cap  = (cap_cnt == CAP_LAST);
        cap_exit  = (state == ST_CAPTURE) && last_cap;
        comparing = ((state == ST_SHIFT) && exp_valid) || (state == ST_UNLOAD);
        mis       = {1'b0, SO1 ^ exp1_sr[0]} + {1'b0, SO2 ^ exp2_sr[0]};
        fail_sum  = {1'b0, FAIL_CNT} + {{(CNT_W-1){1'b0}}, mis};
        fail_nx   = FAIL_CNT;
        if (new_run)        fail_nx = '0;
        else if (comparing) fail_nx = fail_sum[CNT_W] ? '1 : fail_sum[CNT_W-1:0];
        state_nx = state;
        case (state)
            ST_IDLE, ST_WAIT_PAT, ST_DONE: if (xfer) state_nx = ST_SHIFT;
            ST_SHIFT:   if (last_bit) state_nx = ST_CAPTURE;
            ST_CAPTURE: if (last_cap) state_nx = cur_last ? ST_UNLOAD : ST_WAIT_PAT;
            ST_UNLOAD:  if (last_bit) state_nx = ST_DONE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    always_ff @(posedge REFCLK or negedge RESET) begin
        if (!RESET) begin
            PAT_READY      <= 1'b1;
            TESTMODE       <= 1'b0;
            SE             <= 1'b0;
            SI1            <= 1'b0;
            SI2            <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            PASS           <= 1'b0;
            FAIL_CNT       <= '0;
            FIRST_FAIL_PAT <= '0;
            bit_cnt        <= '0;
            cap_cnt        <= '0;
            si1_sr         <= '0;
            si2_sr         <= '0;
            cur_exp1       <= '0;
            cur_exp2       <= '0;
            exp1_sr        <= '0;
            exp2_sr        <= '0;
            cur_last       <= 1'b0;
            exp_valid      <= 1'b0;
            pat_idx        <= '0;
        end else begin
            PAT_READY <= (state_nx == ST_IDLE) || (state_nx == ST_WAIT_PAT) || (state_nx == ST_DONE);
            TESTMODE  <= (state_nx == ST_SHIFT) || (state_nx == ST_CAPTURE) ||
                         (state_nx == ST_WAIT_PAT) || (state_nx == ST_UNLOAD);
            SE        <= (state_nx == ST_SHIFT) || (state_nx == ST_UNLOAD);
            BUSY      <= (state_nx != ST_IDLE) && (state_nx != ST_DONE);
            DONE      <= (state_nx == ST_DONE);
            PASS      <= (state_nx == ST_DONE) && (fail_nx == '0);
            FAIL_CNT  <= fail_nx;
            SI1       <= 1'b0;
            SI2       <= 1'b0;
            if (xfer) begin
                SI1      <= PAT_SI1[0];
                SI2      <= PAT_SI2[0];
                si1_sr   <= PAT_SI1 >> 1;
                si2_sr   <= PAT_SI2 >> 1;
                cur_exp1 <= PAT_EXP1;
                cur_exp2 <= PAT_EXP2;
                cur_last <= PAT_LAST;
            end else if ((state == ST_SHIFT) && !last_bit) begin
                SI1    <= si1_sr[0];
                SI2    <= si2_sr[0];
                si1_sr <= si1_sr >> 1;
                si2_sr <= si2_sr >> 1;
            end
            if ((state == ST_SHIFT) || (state == ST_UNLOAD))
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
            if (state == ST_CAPTURE)
                cap_cnt <= last_cap ? '0 : cap_cnt + 1'b1;
            // Responses leaving the chain belong to the pattern before the one being loaded.
            if (comparing) begin
                exp1_sr <= exp1_sr >> 1;
                exp2_sr <= exp2_sr >> 1;
                if ((mis != 2'd0) && (FAIL_CNT == '0))
                    FIRST_FAIL_PAT <= pat_idx - 1'b1;
            end
            if (new_run) begin
                exp_valid      <= 1'b0;
                pat_idx        <= '0;
                FIRST_FAIL_PAT <= '0;
            end
            if (cap_exit) begin
                exp1_sr   <= cur_exp1;
                exp2_sr   <= cur_exp2;
                exp_valid <= 1'b1;
                if (pat_idx != '1) pat_idx <= pat_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scan_pattern_driver.sv
// tb/tb_scan_pattern_driver.sv - scoreboard bench for scan_pattern_driver with a behavioural 2x15 scan model
module tb_scan_pattern_driver;

    logic        REFCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PAT_VALID = 1'b0;
    logic        PAT_LAST = 1'b0;
    logic [14:0] PAT_SI1 = '0, PAT_SI2 = '0, PAT_EXP1 = '0, PAT_EXP2 = '0;
    logic        PAT_READY, TESTMODE, SE, SI1, SI2, BUSY, DONE, PASS;
    logic [7:0]  FAIL_CNT, FIRST_FAIL_PAT;
    logic        SO1, SO2;
    logic        pat_ready_s, testmode_s, se_s, si1_s, si2_s, busy_s, done_s, pass_s;
    logic [3:0]  fail_cnt_s, first_fail_s;

    int checks = 0, failures = 0, se_cnt = 0, lockstep_err = 0;
    bit inv2 = 1'b0;
    logic [14:0] ch1 = '0, ch2 = '0;
    logic        se_d = 1'b0;

    typedef struct {int fa; int fb; int first; bit pass;} res_t;
    res_t sb[$];
    int run_mis, run_first, run_pat;
    bit run_open = 1'b0;

    scan_pattern_driver #(.CHAIN_LEN(15), .CAPTURE_CYC(1), .CNT_W(8)) dut (
        .REFCLK(REFCLK), .RESET(RESET), .PAT_VALID(PAT_VALID), .PAT_READY(PAT_READY),
        .PAT_LAST(PAT_LAST), .PAT_SI1(PAT_SI1), .PAT_SI2(PAT_SI2), .PAT_EXP1(PAT_EXP1),
        .PAT_EXP2(PAT_EXP2), .TESTMODE(TESTMODE), .SE(SE), .SI1(SI1), .SI2(SI2),
        .SO1(SO1), .SO2(SO2), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .FAIL_CNT(FAIL_CNT), .FIRST_FAIL_PAT(FIRST_FAIL_PAT));

    scan_pattern_driver #(.CHAIN_LEN(15), .CAPTURE_CYC(1), .CNT_W(4)) dut_small (
        .REFCLK(REFCLK), .RESET(RESET), .PAT_VALID(PAT_VALID), .PAT_READY(pat_ready_s),
        .PAT_LAST(PAT_LAST), .PAT_SI1(PAT_SI1), .PAT_SI2(PAT_SI2), .PAT_EXP1(PAT_EXP1),
        .PAT_EXP2(PAT_EXP2), .TESTMODE(testmode_s), .SE(se_s), .SI1(si1_s), .SI2(si2_s),
        .SO1(SO1), .SO2(SO2), .BUSY(busy_s), .DONE(done_s), .PASS(pass_s),
        .FAIL_CNT(fail_cnt_s), .FIRST_FAIL_PAT(first_fail_s));

    always #5 REFCLK = ~REFCLK;

    // Scan chains: SI enters at cell 14, SO is cell 0; capture fires once, on the first SE-low edge.
    always @(posedge REFCLK) begin
        se_d <= SE;
        if (SE) begin
            ch1 <= {SI1, ch1[14:1]};
            ch2 <= {SI2, ch2[14:1]};
        end else if (TESTMODE && se_d) begin
            ch2 <= inv2 ? ~ch2 : ch2;
        end
    end
    assign SO1 = ch1[0];
    assign SO2 = ch2[0];

    always @(negedge REFCLK) begin
        if (SE) se_cnt++;
        if ({pat_ready_s, testmode_s, se_s, si1_s, si2_s} !== {PAT_READY, TESTMODE, SE, SI1, SI2})
            lockstep_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic model_pattern(input logic [14:0] s1, s2, e1, e2, input bit last);
        logic [14:0] c2;
        int m;
        res_t r;
        if (!run_open) begin
            run_mis = 0; run_first = -1; run_pat = 0; run_open = 1'b1;
        end
        c2 = inv2 ? ~s2 : s2;
        m = $countones(s1 ^ e1) + $countones(c2 ^ e2);
        if (m > 0 && run_first < 0) run_first = run_pat;
        run_mis += m;
        run_pat++;
        if (last) begin
            r.fa = sat(run_mis, 255);
            r.fb = sat(run_mis, 15);
            r.first = (run_first < 0) ? 0 : run_first;
            r.pass = (run_mis == 0);
            sb.push_back(r);
            run_open = 1'b0;
        end
    endtask

    task automatic send(input logic [14:0] s1, s2, e1, e2, input bit last);
        int n;
        @(negedge REFCLK);
        PAT_SI1 = s1; PAT_SI2 = s2; PAT_EXP1 = e1; PAT_EXP2 = e2; PAT_LAST = last;
        PAT_VALID = 1'b1;
        n = 0;
        while (!PAT_READY && n < 400) begin
            @(negedge REFCLK);
            n++;
        end
        check("xfer_ready", PAT_READY, 1);
        model_pattern(s1, s2, e1, e2, last);
        @(posedge REFCLK);
        #1 PAT_VALID = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        res_t r;
        int n;
        n = 0;
        while (!DONE && n < 2000) begin
            @(negedge REFCLK);
            n++;
        end
        check({tag, ".done"}, DONE, 1);
        check({tag, ".sb_level"}, sb.size(), 1);
        if (sb.size() > 0) begin
            r = sb.pop_front();
            check({tag, ".fail_cnt"}, FAIL_CNT, r.fa);
            check({tag, ".pass"}, PASS, r.pass);
            check({tag, ".busy"}, BUSY, 0);
            check({tag, ".fail_cnt_w4"}, fail_cnt_s, r.fb);
            check({tag, ".pass_w4"}, pass_s, r.pass);
            check({tag, ".done_w4"}, done_s, 1);
            check({tag, ".busy_w4"}, busy_s, 0);
            if (r.fa != 0) begin
                check({tag, ".first_fail"}, FIRST_FAIL_PAT, r.first);
                check({tag, ".first_fail_w4"}, first_fail_s, r.first);
            end
        end
    endtask

    initial begin
        logic [30:0] sev;
        int base, rdy, hi, ok;
        #2 RESET = 1'b0;
        repeat (2) @(negedge REFCLK);
        check("rst.ready", PAT_READY, 1);
        check("rst.se", SE, 0);
        check("rst.testmode", TESTMODE, 0);
        check("rst.busy", BUSY, 0);
        check("rst.done", DONE, 0);
        check("rst.pass", PASS, 0);
        check("rst.fail_cnt", FAIL_CNT, 0);
        RESET = 1'b1;

        // abort in the middle of a shift
        send(15'h7FFF, 15'h7FFF, 15'h0000, 15'h0000, 1'b0);
        repeat (8) @(negedge REFCLK);
        check("abort.se_before", SE, 1);
        check("abort.si1_before", SI1, 1);
        #1 RESET = 1'b0;
        #1;
        check("abort.se", SE, 0);
        check("abort.testmode", TESTMODE, 0);
        check("abort.si1", SI1, 0);
        check("abort.ready", PAT_READY, 1);
        check("abort.fail_cnt", FAIL_CNT, 0);
        check("abort.done", DONE, 0);
        repeat (2) @(negedge REFCLK);
        RESET = 1'b1;
        #1 base = se_cnt;
        repeat (30) @(negedge REFCLK);
        #1 check("abort.no_se", se_cnt - base, 0);
        run_open = 1'b0;

        send(15'h0000, 15'h0000, 15'h0000, 15'h0000, 1'b1);
        for (int i = 0; i < 31; i++) begin
            @(negedge REFCLK);
            sev[30-i] = SE;
        end
        check("single.se_seq", sev, 31'h7FFF7FFF);
        wait_result("single");

        #1 base = se_cnt;
        send(15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF, 1'b0);
        send(15'h5A5A, 15'h5A5A, 15'h5A5A, 15'h5A5A, 1'b1);
        wait_result("two");
        #1 check("two.se_cycles", se_cnt - base, 45);

        inv2 = 1'b1;
        send(15'h0000, 15'h0001, 15'h0000, 15'h0001, 1'b1);
        wait_result("inv2");
        inv2 = 1'b0;

        for (int p = 0; p < 3; p++)
            send(15'h0000, 15'h0000, 15'h7FFF, 15'h7FFF, p == 2);
        wait_result("sat");

        send(15'h1111, 15'h1111, 15'h1111, 15'h1111, 1'b0);
        send(15'h2222, 15'h2222, 15'h2221, 15'h2222, 1'b1);
        wait_result("second_fails");

        // valid held through the shift, then withheld in WAIT_PAT
        send(15'h2468, 15'h2468, 15'h2468, 15'h2468, 1'b0);
        PAT_SI1 = 15'h1234; PAT_SI2 = 15'h1234; PAT_EXP1 = 15'h4321; PAT_EXP2 = 15'h4321;
        PAT_LAST = 1'b1; PAT_VALID = 1'b1;
        rdy = 0; hi = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge REFCLK);
            rdy += int'(PAT_READY);
            hi += int'(SE);
        end
        check("hold.no_xfer", rdy, 0);
        check("hold.se_len", hi, 15);
        PAT_VALID = 1'b0;
        @(negedge REFCLK);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge REFCLK);
            if (SE == 1'b0 && TESTMODE == 1'b1 && PAT_READY == 1'b1) ok++;
        end
        check("hold.wait_state", ok, 20);
        PAT_SI1 = 15'h0F0F; PAT_SI2 = 15'h70F0; PAT_EXP1 = 15'h0F0F; PAT_EXP2 = 15'h70F0;
        PAT_LAST = 1'b1; PAT_VALID = 1'b1;
        model_pattern(15'h0F0F, 15'h70F0, 15'h0F0F, 15'h70F0, 1'b1);
        @(posedge REFCLK);
        #1 PAT_VALID = 1'b0;
        @(negedge REFCLK);
        check("hold.accept", SE, 1);
        wait_result("hold");

        check("lockstep", lockstep_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scan_pattern_driver.md
Name: scan_pattern_driver

Overview:
On-chip scan pattern driver: the initiating end of the two-chain scan interface (TESTMODE/SE/SI1/SI2 out, SO1/SO2 in) used by the DFT core.
- Accepts parallel scan patterns over a valid/ready handshake.
- Serialises each pattern into both chains, issues capture cycles, then unloads and compares the responses against expected values.
- Reports a pass/fail result, a bit-mismatch count and the index of the first failing pattern.

Parameters:
CHAIN_LEN, 15, cells per scan chain; shift and unload each last exactly CHAIN_LEN cycles
CAPTURE_CYC, 1, number of capture cycles (SE=0, TESTMODE=1) per pattern, minimum 1
CNT_W, 8, width of FAIL_CNT and PAT_IDX

Ports:
REFCLK  in  1  single clock; all state updates on rising edge
RESET  in  1  asynchronous, active-low reset
PAT_VALID  in  1  pattern offered
PAT_READY  out  1  driver can accept a pattern this cycle
PAT_LAST  in  1  offered pattern is the final one of the run
PAT_SI1  in  CHAIN_LEN  stimulus for chain 1; bit k driven on shift cycle k
PAT_SI2  in  CHAIN_LEN  stimulus for chain 2
PAT_EXP1  in  CHAIN_LEN  expected chain-1 response; bit k compared on unload cycle k
PAT_EXP2  in  CHAIN_LEN  expected chain-2 response
TESTMODE  out  1  test mode enable to core
SE  out  1  scan enable
SI1  out  1  scan-in chain 1
SI2  out  1  scan-in chain 2
SO1  in  1  scan-out chain 1
SO2  in  1  scan-out chain 2
BUSY  out  1  run in progress
DONE  out  1  run complete, result valid
PASS  out  1  DONE and FAIL_CNT==0
FAIL_CNT  out  CNT_W  total mismatching bits, saturating
FIRST_FAIL_PAT  out  CNT_W  index of first pattern with any mismatch; valid when FAIL_CNT!=0

Behaviour:
- Reset (RESET=0, asynchronous, any state): state=IDLE.
  - All outputs 0 except PAT_READY=1.
  - Internal pattern and expect registers, the exp_valid flag and all counters are cleared.
  - Reset during shift, capture or unload aborts the run with no further SE pulses.
- All outputs are registered. A "shift cycle" is a cycle in which the SE output is 1.
- Handshake: a transfer occurs on a rising edge with PAT_VALID&&PAT_READY.
  - PAT_READY=1 only in IDLE, WAIT_PAT and DONE.
  - PAT_VALID in any other state is ignored; PAT_* inputs are sampled only at transfer.
- IDLE/DONE: TESTMODE=0, SE=0, SI=0.
  - Transfer from IDLE or DONE starts a new run: DONE, FAIL_CNT, PAT_IDX, FIRST_FAIL_PAT and exp_valid cleared; BUSY=1; go to SHIFT.
- SHIFT: TESTMODE=1, SE=1 for exactly CHAIN_LEN consecutive cycles.
  - Cycle k (0..CHAIN_LEN-1) drives SI1=PAT_SI1[k] and SI2=PAT_SI2[k].
  - If exp_valid, SO1/SO2 sampled at the edge ending cycle k are compared with the previous pattern's EXP1[k]/EXP2[k] (unload overlaps load).
  - Then go to CAPTURE.
- CAPTURE: TESTMODE=1, SE=0, SI=0 for CAPTURE_CYC cycles.
  - On exit: current EXP1/EXP2 move to the expect registers, exp_valid=1, PAT_IDX+=1 (saturating).
  - If the pattern had PAT_LAST=1, go to UNLOAD; otherwise go to WAIT_PAT.
- WAIT_PAT: TESTMODE=1, SE=0, PAT_READY=1; holds indefinitely. Transfer goes to SHIFT.
- UNLOAD: TESTMODE=1, SE=1, SI=0 for CHAIN_LEN cycles, comparing as in SHIFT. Then go to DONE.
- DONE: DONE=1, BUSY=0, TESTMODE=0; results are held until the next transfer or reset.
- Compare arithmetic:
  - Per shift cycle, mismatch = (SO1!=exp1[k]) + (SO2!=exp2[k]), range 0..2.
  - FAIL_CNT += mismatch, saturating at 2^CNT_W-1; it never wraps.
- FIRST_FAIL_PAT is loaded with the index of the pattern being unloaded (PAT_IDX-1) on the first cycle with mismatch>0 while FAIL_CNT==0; it is held afterwards.
- Latency per pattern: CHAIN_LEN+CAPTURE_CYC cycles plus handshake wait; final unload adds CHAIN_LEN cycles.
- Simultaneous events: a transfer on the same edge that WAIT_PAT is entered is not possible, because PAT_READY is registered and asserts the cycle after entry.

Test Plan:
- Reset mid-SHIFT (cycle 7): SE, TESTMODE, SI drop to 0 asynchronously; PAT_READY=1, FAIL_CNT=0, DONE=0; no further SE pulses.
- Single pattern, behavioural 2×15 scan model with capture=identity, SI1=SI2=15'h0000, EXP=15'h0000, PAT_LAST=1:
  - SE=1 for 15 cycles, SE=0 for 1 cycle, SE=1 for 15 cycles.
  - DONE=1, PASS=1, FAIL_CNT=0.
- Two patterns, SI=15'h7FFF then 15'h5A5A with matching expects:
  - Unload of pattern 0 overlaps shift of pattern 1.
  - PASS=1, PAT_IDX=2; total SE-high cycles=45.
- Model inverts chain-2 capture, pattern SI2=15'h0001, EXP2=15'h0001, PAT_LAST=1: FAIL_CNT=15, FIRST_FAIL_PAT=0, PASS=0.
- CNT_W=4, three all-mismatch patterns (90 mismatching bits): FAIL_CNT saturates at 15 with no wrap; FIRST_FAIL_PAT=0.
- PAT_VALID held high during SHIFT, with PAT_VALID withheld for 20 cycles in WAIT_PAT:
  - No transfer during SHIFT.
  - SE stays 0 and TESTMODE stays 1 through the wait.
  - Next pattern is accepted the cycle PAT_VALID rises.
